dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-port data memory between the RV32I core's load/store path and a debug/loader port, and sequences a full-memory zero-fill after reset or on command. It sits between the core, the debug port and the `dmem` array. It drives the memory's `we`, `a` and `wd` inputs and routes the memory's asynchronous `rd` back to whichever requester holds the grant. The core is stalled whenever it loses arbitration or a clear is running.

## Interface

Parameters:

- `DEPTH`, 64: number of 32-bit words in the data memory.
- `CW`, 6: clear-counter width; must satisfy 2^CW >= DEPTH.

Ports:

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `cpu_req`, in, 1: core requests a memory access this cycle.
- `cpu_we`, in, 1: core access is a store.
- `cpu_a`, in, 32: core byte address.
- `cpu_wd`, in, 32: core store data.
- `cpu_rd`, out, 32: load data; equals `mem_rd` while the core is granted, otherwise 0.
- `cpu_stall`, out, 1: equals `cpu_req & ~cpu_gnt`; the core holds its PC and request.
- `dbg_req`, in, 1: debug/loader request. Must be held stable until granted.
- `dbg_we`, in, 1: debug access is a write.
- `dbg_a`, in, 32: debug byte address.
- `dbg_wd`, in, 32: debug write data.
- `dbg_gnt`, out, 1: the debug access completes at this clock edge.
- `dbg_rd`, out, 32: registered debug read data.
- `dbg_rvalid`, out, 1: one-cycle pulse marking valid `dbg_rd`.
- `clr_start`, in, 1: request a zero-fill of the whole memory.
- `clr_busy`, out, 1: a clear is in progress.
- `clr_done`, out, 1: one-cycle pulse after the last clear write.
- `mem_we`, out, 1: write enable to the memory.
- `mem_a`, out, 32: byte address to the memory.
- `mem_wd`, out, 32: write data to the memory.
- `mem_rd`, in, 32: asynchronous read data from the memory.

## Operation

- There are two states, `CLEAR` and `ARB`. Reset forces `CLEAR`, clears the counter to 0 and sets the priority pointer to `CPU`.
- In `CLEAR`:
  - Outputs are `mem_we=1`, `mem_a={counter,2'b00}` zero-extended to 32 bits, `mem_wd=0`, `clr_busy=1`, and both grants 0.
  - The counter increments each edge.
  - On the edge where counter == DEPTH-1, the block goes to `ARB`, the counter returns to 0 and `clr_done` is registered high for one cycle.
- While `reset` is low, the block sits in `CLEAR` with counter 0, so a write of 0 to word 0 is presented. This is harmless and intended.
- In `ARB` with `clr_start=1`: the block moves to `CLEAR` at the next edge. No grant is issued in that cycle, so the clear takes precedence over simultaneous requests.
- `clr_start` is ignored while in `CLEAR`.
- Arbitration in `ARB`:
  - With one requester active, that requester is granted.
  - With both active, the port named by the pointer is granted. The pointer then flips to the other port.
  - Whenever only one port is requesting, it is granted and the pointer does not change.
- When a port is granted, `mem_we`, `mem_a` and `mem_wd` mirror that port's `we`, `a` and `wd`. With no grant, `mem_we=0`, `mem_a=0` and `mem_wd=0`.
- A debug read (`dbg_gnt & ~dbg_we`) captures `mem_rd` into `dbg_rd` at the grant edge and sets `dbg_rvalid` for the next cycle.
- `dbg_rd` holds its value until the next debug read.
- Addresses pass through unchanged; range and alignment checking belong to the memory.

## Timing

- Reset values:
  - `clr_busy=1`, `clr_done=0`, `dbg_rvalid=0`, `dbg_rd=0`, `dbg_gnt=0`.
  - `cpu_stall=cpu_req`, `cpu_rd=0`.
  - `mem_we=1`, `mem_a=0`, `mem_wd=0`.
- After `reset` rises, the clear takes exactly DEPTH edges. `clr_done` is high during the first `ARB` cycle.
- `cpu_gnt`, `dbg_gnt`, `cpu_stall`, `cpu_rd` and the `mem_*` outputs are combinational from state, pointer and requests, with zero added latency.
- Core loads complete in the grant cycle.
- Debug reads have 1-cycle latency from `dbg_gnt` to `dbg_rvalid`. A new debug read may be granted in the same cycle that `dbg_rvalid` is high.
- A reset assertion mid-clear or mid-access aborts the operation immediately. `dbg_rvalid` drops, and the clear restarts from word 0 after reset is released.

## Test plan

- Reset release with DEPTH=64: 64 consecutive writes of 0 to addresses 0x00, 0x04, … 0xFC. `clr_done` pulses at cycle 64, and `cpu_stall=1` throughout if `cpu_req=1`.
- Core store then load in `ARB`: store 0xDEADBEEF to 0x10. On the next cycle `cpu_rd=0xDEADBEEF` with `cpu_stall=0`.
- Contention: both ports request for 4 cycles. Grants alternate CPU, DBG, CPU, DBG, and `cpu_stall` is high in cycles 2 and 4.
- Debug read of 0x20 holding 0x12345678: `dbg_gnt` in cycle N, then `dbg_rvalid=1` with `dbg_rd=0x12345678` in cycle N+1.
- `clr_start` together with `cpu_req`: no grant that cycle, 64 clear writes follow, then `clr_done`, then the core is granted. A `clr_start` pulse during the clear has no effect.
- Reset asserted at clear word 30: `mem_a` returns to 0, and after release a full 64-write clear runs.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-port dmem between the core and the debug/loader
// port, and zero-fills the whole memory after reset or when clr_start is raised.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_CLEAR | writing 0 to word r_cnt, both grants held off
//   S_ARB   | normal operation, round-robin on contention
module dmem_arbiter #(
    parameter int DEPTH = 64,
    parameter int CW    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_a,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rd,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_a,
    input  logic [31:0] dbg_wd,
    output logic        dbg_gnt,
    output logic [31:0] dbg_rd,
    output logic        dbg_rvalid,
    input  logic        clr_start,
    output logic        clr_busy,
    output logic        clr_done,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic {S_CLEAR, S_ARB} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_ptr_dbg;
    logic          r_clr_done;
    logic          r_dbg_rvalid;
    logic [31:0]   r_dbg_rd;

    logic w_arb;
    logic w_both;
    logic w_cpu_gnt;
    logic w_dbg_gnt;

    // A clr_start seen in ARB suppresses both grants so the clear wins that cycle.
    assign w_arb     = (r_state == S_ARB) & ~clr_start;
    assign w_both    = cpu_req & dbg_req;
    assign w_cpu_gnt = w_arb & cpu_req & (~dbg_req | ~r_ptr_dbg);
    assign w_dbg_gnt = w_arb & dbg_req & (~cpu_req | r_ptr_dbg);

    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (r_state == S_CLEAR) begin
            mem_we = 1'b1;
            mem_a  = {{(30-CW){1'b0}}, r_cnt, 2'b00};
        end else if (w_cpu_gnt) begin
            mem_we = cpu_we;
            mem_a  = cpu_a;
            mem_wd = cpu_wd;
        end else if (w_dbg_gnt) begin
            mem_we = dbg_we;
            mem_a  = dbg_a;
            mem_wd = dbg_wd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_CLEAR;
            r_cnt        <= '0;
            r_ptr_dbg    <= 1'b0;
            r_clr_done   <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_dbg_rd     <= '0;
        end else begin
            r_clr_done   <= 1'b0;
            r_dbg_rvalid <= w_dbg_gnt & ~dbg_we;
            if (w_dbg_gnt & ~dbg_we) begin
                r_dbg_rd <= mem_rd;
            end
            case (r_state)
                S_CLEAR: begin
                    if (r_cnt == CW'(DEPTH - 1)) begin
                        r_state    <= S_ARB;
                        r_cnt      <= '0;
                        r_clr_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ARB: begin
                    if (clr_start) begin
                        r_state <= S_CLEAR;
                    end else if (w_both) begin
                        r_ptr_dbg <= ~r_ptr_dbg;
                    end
                end
            endcase
        end
    end

    assign cpu_rd     = w_cpu_gnt ? mem_rd : '0;
    assign cpu_stall  = cpu_req & ~w_cpu_gnt;
    assign dbg_gnt    = w_dbg_gnt;
    assign dbg_rd     = r_dbg_rd;
    assign dbg_rvalid = r_dbg_rvalid;
    assign clr_busy   = (r_state == S_CLEAR);
    assign clr_done   = r_clr_done;

endmodule
